// File: rtl/dff_pipe.sv
// Multi-stage register pipeline with per-stage valid bits, valid/ready flow
// control, bubble collapsing, synchronous flush and a registered occupancy count.
module dff_pipe #(
    parameter int unsigned           WIDTH     = 8,
    parameter int unsigned           DEPTH     = 3,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0,
    localparam int unsigned          CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_async,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    occupancy
);

    // Handshake: a word moves across a port on a rising edge where valid and
    // ready are both high; valid never depends on ready, ready may depend on
    // downstream ready (out_ready -> in_ready is the only combinational path).

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [CW-1:0]    occ;

    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] src_vld;
    logic [WIDTH-1:0] src_dat [DEPTH];
    logic             xfer_in;
    logic             xfer_out;

    // A stage can load when the stage ahead is loading or it is empty itself,
    // which is what lets bubbles collapse while the consumer stalls.
    always_comb begin
        rdy            = '0;
        rdy[DEPTH-1]   = out_ready | ~vld[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy[i] = rdy[i+1] | ~vld[i];
        end
    end

    always_comb begin
        src_vld    = '0;
        src_dat[0] = in_data;
        src_vld[0] = in_valid & ~flush;
        for (int i = 1; i < DEPTH; i++) begin
            src_vld[i] = vld[i-1];
            src_dat[i] = dat[i-1];
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
    assign occupancy = occ;

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = vld[DEPTH-1] & out_ready;

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            vld <= '0;
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= RESET_VAL;
            end
        end else if (flush) begin
            vld <= '0;
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    vld[i] <= src_vld[i];
                    // A bubble leaves the data register untouched.
                    if (src_vld[i]) begin
                        dat[i] <= src_dat[i];
                    end
                end
            end
            occ <= occ + CW'(xfer_in) - CW'(xfer_out);
        end
    end

endmodule
